// File: rtl/wake_gate_ctrl_if.sv
// Adapter-facing signal bundle for wake_gate_ctrl: wake requests, link status and
// the gate/ack/timeout responses. The controller uses the slave modport.
interface wake_gate_ctrl_if #(
  parameter int NUM_REQ = 2,
  parameter int IDLE_W  = 8,
  parameter int TO_W    = 10
);
  logic [3:0]         i_lp_state_req;
  logic [NUM_REQ-1:0] i_lp_wake_req;
  logic [3:0]         i_pl_state_sts;
  logic               i_sb_msg_valid;
  logic               i_ltsm_is_waked_up;
  logic               i_ltsm_in_reset;
  logic [IDLE_W-1:0]  i_idle_thresh;
  logic [TO_W-1:0]    i_ack_timeout;
  logic               o_clk_gate_en;
  logic [NUM_REQ-1:0] o_pl_wake_ack;
  logic               o_wake_timeout;
  logic [1:0]         o_state;

  modport master (
    output i_lp_state_req, i_lp_wake_req, i_pl_state_sts, i_sb_msg_valid,
           i_ltsm_is_waked_up, i_ltsm_in_reset, i_idle_thresh, i_ack_timeout,
    input  o_clk_gate_en, o_pl_wake_ack, o_wake_timeout, o_state
  );

  modport slave (
    input  i_lp_state_req, i_lp_wake_req, i_pl_state_sts, i_sb_msg_valid,
           i_ltsm_is_waked_up, i_ltsm_in_reset, i_idle_thresh, i_ack_timeout,
    output o_clk_gate_en, o_pl_wake_ack, o_wake_timeout, o_state
  );
endinterface

// File: rtl/wake_gate_ctrl.sv
// Mainband clock-gate controller: gates after idle hysteresis, wakes on request.
// Define WAKE_ACK_TIMEOUT_EN to add the wake-acknowledge timeout counter and pulse.
module wake_gate_ctrl #(
  parameter int NUM_REQ = 2,
  parameter int IDLE_W  = 8,
  parameter int TO_W    = 10
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  wake_gate_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    ST_GATED     = 2'b00,
    ST_WAKING    = 2'b01,
    ST_ACTIVE    = 2'b10,
    ST_IDLE_WAIT = 2'b11
  } state_e;

  state_e              state_q, state_d;
  logic [IDLE_W-1:0]   idle_cnt_q, idle_cnt_d;
  logic                clk_gate_en_q, clk_gate_en_d;
  logic [NUM_REQ-1:0]  wake_ack_q, wake_ack_d;
  logic                wake_src;
  logic                gate_cond;

  always_comb begin
    wake_src  = (|bus.i_lp_wake_req) | bus.i_sb_msg_valid;
    gate_cond = ((bus.i_pl_state_sts == 4'b0000) && bus.i_ltsm_in_reset &&
                 (bus.i_lp_state_req == 4'b0000)) ||
                (bus.i_pl_state_sts == 4'b0100) || (bus.i_pl_state_sts == 4'b1000) ||
                (bus.i_pl_state_sts == 4'b1001) || (bus.i_pl_state_sts == 4'b1100);
  end

  // The idle counter is zero outside IDLE_WAIT, so every state entry clears it.
  always_comb begin
    state_d    = state_q;
    idle_cnt_d = '0;
    case (state_q)
      ST_GATED:     if (wake_src) state_d = ST_WAKING;
      ST_WAKING:    if (bus.i_ltsm_is_waked_up) state_d = ST_ACTIVE;
      ST_ACTIVE:    if (gate_cond && !wake_src) state_d = ST_IDLE_WAIT;
      ST_IDLE_WAIT: begin
        if (wake_src || !gate_cond)              state_d = ST_ACTIVE;
        else if (idle_cnt_q == bus.i_idle_thresh) state_d = ST_GATED;
        else idle_cnt_d = (&idle_cnt_q) ? idle_cnt_q : idle_cnt_q + 1'b1;
      end
    endcase
    clk_gate_en_d = (state_q != ST_GATED);
    wake_ack_d    = bus.i_lp_wake_req &
                    {NUM_REQ{bus.i_ltsm_is_waked_up && (state_q != ST_GATED)}};
  end

`ifdef WAKE_ACK_TIMEOUT_EN
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            wake_timeout_q, wake_timeout_d;

  // A timeout restarts the count so the pulse repeats while the ack stays missing.
  always_comb begin
    to_cnt_d       = '0;
    wake_timeout_d = 1'b0;
    if ((state_q == ST_WAKING) && !bus.i_ltsm_is_waked_up) begin
      if (to_cnt_q == bus.i_ack_timeout) wake_timeout_d = 1'b1;
      else to_cnt_d = (&to_cnt_q) ? to_cnt_q : to_cnt_q + 1'b1;
    end
  end
`else
  logic unused_ack_timeout;
  assign unused_ack_timeout = ^bus.i_ack_timeout;
`endif

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q        <= ST_GATED;
      idle_cnt_q     <= '0;
      clk_gate_en_q  <= 1'b0;
      wake_ack_q     <= '0;
`ifdef WAKE_ACK_TIMEOUT_EN
      to_cnt_q       <= '0;
      wake_timeout_q <= 1'b0;
`endif
    end else begin
      state_q        <= state_d;
      idle_cnt_q     <= idle_cnt_d;
      clk_gate_en_q  <= clk_gate_en_d;
      wake_ack_q     <= wake_ack_d;
`ifdef WAKE_ACK_TIMEOUT_EN
      to_cnt_q       <= to_cnt_d;
      wake_timeout_q <= wake_timeout_d;
`endif
    end
  end

  assign bus.o_state       = state_q;
  assign bus.o_clk_gate_en = clk_gate_en_q;
  assign bus.o_pl_wake_ack = wake_ack_q;
`ifdef WAKE_ACK_TIMEOUT_EN
  assign bus.o_wake_timeout = wake_timeout_q;
`else
  assign bus.o_wake_timeout = 1'b0;
`endif

endmodule
